// File: rtl/fpu_ret_gather.sv
//------------------------------------------------------------------------------
// fpu_ret_gather
//   Gathers retire tags from FPU lanes 1/3/5 into a circular FIFO and presents
//   the two oldest entries to the retire consumer. Tracks sticky exception
//   flags and an overflow flag.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fpu_ret_gather #(
    parameter int DEPTH      = 8,
    parameter int STALL_FREE = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [13:0]              i_u1_ret,
    input  logic [13:0]              i_u3_ret,
    input  logic [13:0]              i_u5_ret,
    input  logic                     i_u1_ret_en,
    input  logic                     i_u3_ret_en,
    input  logic                     i_u5_ret_en,
    input  logic [5:0]               i_fus0,
    input  logic [5:0]               i_fus1,
    input  logic [5:0]               i_fus2,
    input  logic                     i_rt_rdy,
    input  logic                     i_exc_clr,
    output logic [13:0]              o_rt_data0,
    output logic [13:0]              o_rt_data1,
    output logic                     o_rt_vld0,
    output logic                     o_rt_vld1,
    output logic [$clog2(DEPTH):0]   o_fifo_cnt,
    output logic                     o_stall_out,
    output logic [5:0]               o_exc_acc,
    output logic                     o_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

    logic [13:0]   r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_cnt;
    logic          r_stall;
    logic [5:0]    r_exc;
    logic          r_ovf;

    logic          w_vld0, w_vld1;
    logic [CW-1:0] w_pops, w_free, w_pos3, w_pos5, w_push, w_cnt_nxt;
    logic          w_acc1, w_acc3, w_acc5, w_drop;
    logic [AW-1:0] w_a3, w_a5, w_rd1;
    logic [31:0]   w_space;
    logic          w_stall_nxt;
    logic [5:0]    w_exc_set;

    assign w_vld0 = (r_cnt >= CW'(1));
    assign w_vld1 = (r_cnt >= CW'(2));
    assign w_pops = i_rt_rdy ? (CW'(w_vld0) + CW'(w_vld1)) : '0;
    // Pops retire first, so their slots are reusable by this cycle's push.
    assign w_free = c_DEPTH - r_cnt + w_pops;

    // Enabled lanes are packed in u1, u3, u5 order; each tag's position in
    // that packing decides both its write slot and whether it fits.
    assign w_pos3 = CW'(i_u1_ret_en);
    assign w_pos5 = w_pos3 + CW'(i_u3_ret_en);
    assign w_acc1 = i_u1_ret_en && (w_free != '0);
    assign w_acc3 = i_u3_ret_en && (w_pos3 < w_free);
    assign w_acc5 = i_u5_ret_en && (w_pos5 < w_free);
    assign w_push = CW'(w_acc1) + CW'(w_acc3) + CW'(w_acc5);
    assign w_drop = (i_u1_ret_en && !w_acc1) || (i_u3_ret_en && !w_acc3) ||
                    (i_u5_ret_en && !w_acc5);

    assign w_a3  = r_wr_ptr + AW'(w_pos3);
    assign w_a5  = r_wr_ptr + AW'(w_pos5);
    assign w_rd1 = r_rd_ptr + AW'(1);

    assign w_cnt_nxt   = r_cnt - w_pops + w_push;
    assign w_space     = 32'(DEPTH) - 32'(w_cnt_nxt);
    assign w_stall_nxt = (w_space < 32'(STALL_FREE));

    assign w_exc_set = (i_u1_ret_en ? i_fus0 : 6'd0) |
                       (i_u3_ret_en ? i_fus1 : 6'd0) |
                       (i_u5_ret_en ? i_fus2 : 6'd0);

    always_ff @(posedge clk) begin
        if (w_acc1) r_mem[r_wr_ptr] <= i_u1_ret;
        if (w_acc3) r_mem[w_a3]     <= i_u3_ret;
        if (w_acc5) r_mem[w_a5]     <= i_u5_ret;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
            r_stall  <= 1'b0;
            r_exc    <= 6'd0;
            r_ovf    <= 1'b0;
        end else begin
            r_rd_ptr <= r_rd_ptr + AW'(w_pops);
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_cnt    <= w_cnt_nxt;
            r_stall  <= w_stall_nxt;
            r_exc    <= (i_exc_clr ? 6'd0 : r_exc) | w_exc_set;
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    assign o_rt_data0  = r_mem[r_rd_ptr];
    assign o_rt_data1  = r_mem[w_rd1];
    assign o_rt_vld0   = w_vld0;
    assign o_rt_vld1   = w_vld1;
    assign o_fifo_cnt  = r_cnt;
    assign o_stall_out = r_stall;
    assign o_exc_acc   = r_exc;
    assign o_ovf       = r_ovf;

endmodule

`default_nettype wire
